// File: rtl/mat4x4_stream_io_if.sv
// Valid/ready byte streams of mat4x4_stream_io: operand bytes in, result bytes out.
interface mat4x4_stream_io_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mat4x4_stream_io.sv
// Byte-stream front end for the 4x4 8-bit matrix multiplier: loads A/B bytes,
// pulses start, waits for done (with optional timeout) and streams the result.
module mat4x4_stream_io #(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mat4x4_stream_io_if.slave io,
  output logic [127:0]      a_flat,
  output logic [127:0]      b_flat,
  output logic              start,
  input  logic              done,
  input  logic [127:0]      s_flat,
  output logic              err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {LOAD, START, WAIT, SEND} state_t;

  state_t        state, state_d;
  logic [4:0]    idx, idx_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [127:0]  s_hold;
  logic          live;
  logic          in_hs, out_hs, capture, timeout;

  // live keeps in_ready low for the first cycle after rst, while state is already LOAD.
  assign io.in_ready  = live && (state == LOAD);
  assign start        = (state == START);
  assign io.out_valid = (state == SEND);
  assign io.out_last  = (state == SEND) && (idx == 5'd15);
  assign io.out_data  = (state == SEND) ? s_hold[{idx[3:0], 3'b000} +: 8] : 8'd0;

  assign in_hs  = io.in_valid && io.in_ready;
  assign out_hs = io.out_ready && (state == SEND);

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    capture = 1'b0;
    timeout = 1'b0;
    unique case (state)
      LOAD: begin
        if (in_hs) begin
          idx_d = idx + 5'd1;
          if (idx == 5'd31) begin
            state_d = START;
            idx_d   = '0;
          end
        end
      end
      START: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (done) begin
          capture = 1'b1;
          state_d = SEND;
          idx_d   = '0;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          timeout = 1'b1;
          state_d = LOAD;
          idx_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SEND: begin
        if (out_hs) begin
          idx_d = idx + 5'd1;
          if (idx == 5'd15) begin
            state_d = LOAD;
            idx_d   = '0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOAD;
      idx    <= '0;
      cnt    <= '0;
      live   <= 1'b0;
      err    <= 1'b0;
      // NOTE: the wide operand/result registers are reset because they drive outputs directly.
      a_flat <= '0;
      b_flat <= '0;
      s_hold <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
      live  <= 1'b1;
      if (in_hs) begin
        if (idx[4]) b_flat[{idx[3:0], 3'b000} +: 8] <= io.in_data;
        else        a_flat[{idx[3:0], 3'b000} +: 8] <= io.in_data;
      end
      if (capture) s_hold <= s_flat;
      if (timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mat4x4_stream_io.sv
// Self-checking bench for mat4x4_stream_io: a behavioural multiplier feeds s_flat and
// a queue of expected result bytes is compared against the output stream.
`timescale 1ns/1ps
module tb_mat4x4_stream_io;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, sel, in_valid, out_ready, done;
  logic [7:0]   in_data;
  logic [127:0] s_flat;
  logic         rst_a, rst_b;

  // sel picks which instance is active; the other one is held in reset.
  assign rst_a = rst | sel;
  assign rst_b = rst | ~sel;

  mat4x4_stream_io_if bus_a ();
  mat4x4_stream_io_if bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.out_ready = out_ready;

  logic [127:0] a_flat_a, b_flat_a, a_flat_b, b_flat_b;
  logic         start_a, start_b, err_a, err_b;

  mat4x4_stream_io #(.TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst_a), .io(bus_a), .a_flat(a_flat_a), .b_flat(b_flat_a),
    .start(start_a), .done(done), .s_flat(s_flat), .err(err_a)
  );

  mat4x4_stream_io #(.TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst_b), .io(bus_b), .a_flat(a_flat_b), .b_flat(b_flat_b),
    .start(start_b), .done(done), .s_flat(s_flat), .err(err_b)
  );

  logic         in_ready, out_valid, out_last, start, err;
  logic [7:0]   out_data;
  logic [127:0] a_flat, b_flat;

  assign in_ready  = sel ? bus_b.in_ready  : bus_a.in_ready;
  assign out_valid = sel ? bus_b.out_valid : bus_a.out_valid;
  assign out_last  = sel ? bus_b.out_last  : bus_a.out_last;
  assign out_data  = sel ? bus_b.out_data  : bus_a.out_data;
  assign start     = sel ? start_b  : start_a;
  assign err       = sel ? err_b    : err_a;
  assign a_flat    = sel ? a_flat_b : a_flat_a;
  assign b_flat    = sel ? b_flat_b : b_flat_a;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [127:0] matmul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] s;
    logic [7:0]   acc;
    s = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        acc = 8'd0;
        for (int k = 0; k < 4; k++)
          acc = acc + 8'(a[8*(4*r+k) +: 8] * b[8*(4*k+c) +: 8]);
        s[8*(4*r+c) +: 8] = acc;
      end
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Streams 32 bytes (A then B); optional 1/0 valid toggling and a done pulse at byte done_at.
  task automatic stream_in(input logic [127:0] a, input logic [127:0] b, input bit gaps,
                           input int done_at);
    int n     = 0;
    int guard = 0;
    int early = 0;
    bit hs;
    bit idle  = 1'b0;
    while (n < 32 && guard < 200) begin
      if (gaps && idle) begin
        in_valid = 1'b0;
        in_data  = 8'hA5;
      end else begin
        in_valid = 1'b1;
        if (n < 16) in_data = a[8*n +: 8];
        else        in_data = b[8*(n-16) +: 8];
      end
      done = (n == done_at);
      hs   = in_valid && in_ready;
      if (start) early++;
      tick();
      if (hs) n++;
      idle = !idle;
      guard++;
    end
    in_valid = 1'b0;
    done     = 1'b0;
    total++;
    if (n != 32 || early != 0) begin
      bad++;
      $display("FAIL load_accept: accepted=%0d early_start=%0d, required 32 and 0", n, early);
    end
  endtask

  task automatic job_in(input logic [127:0] a, input logic [127:0] b, input bit gaps,
                        input int done_at, output logic [127:0] s);
    s = matmul(a, b);
    for (int k = 0; k < 16; k++) exp_q.push_back(s[8*k +: 8]);
    stream_in(a, b, gaps, done_at);
    total++;
    if (start !== 1'b1) begin
      bad++;
      $display("FAIL start_after_byte32: start=%b, required 1", start);
    end
    total++;
    if (a_flat !== a || b_flat !== b) begin
      bad++;
      $display("FAIL operand_flat: a=%h b=%h, required a=%h b=%h", a_flat, b_flat, a, b);
    end
  endtask

  // Multiplier model: done is sampled delay+1 edges after the start cycle begins.
  task automatic job_mult(input int delay, input logic [127:0] s);
    int extra = 0;
    done = 1'b0;
    for (int j = 0; j < delay; j++) begin
      tick();
      if (start) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL start_width: extra start cycles=%0d, required 0", extra);
    end
    s_flat = s;
    done   = 1'b1;
    tick();
    done   = 1'b0;
    s_flat = ~s;
  endtask

  task automatic recv(input int count, input int stall_at, input int stall_len);
    int         n     = 0;
    int         held  = 0;
    int         guard = 0;
    logic [7:0] exp;
    while (n < count && guard < 100) begin
      guard++;
      total++;
      if (out_valid !== 1'b1) begin
        bad++;
        $display("FAIL out_valid byte %0d: out_valid=%b, required 1", n, out_valid);
        n = count;
      end else if (n == stall_at && held < stall_len) begin
        out_ready = 1'b0;
        if (out_data !== exp_q[0]) begin
          bad++;
          $display("FAIL stall_hold byte %0d: data=%h, required %h", n, out_data, exp_q[0]);
        end
        held++;
        tick();
      end else begin
        out_ready = 1'b1;
        exp = exp_q.pop_front();
        if (out_data !== exp || out_last !== (n == 15)) begin
          bad++;
          $display("FAIL out_byte %0d: data=%h last=%b, required %h last=%b",
                   n, out_data, out_last, exp, (n == 15));
        end
        tick();
        n++;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic run_job(input logic [127:0] a, input logic [127:0] b, input bit gaps,
                         input int delay, input int stall_at, input int stall_len,
                         input int done_at);
    logic [127:0] s;
    job_in(a, b, gaps, done_at, s);
    job_mult(delay, s);
    recv(16, stall_at, stall_len);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL return_to_load: in_ready=%b out_valid=%b left=%0d, required 1 0 0",
               in_ready, out_valid, exp_q.size());
    end
  endtask

  function automatic logic [127:0] identity();
    logic [127:0] m = '0;
    for (int k = 0; k < 4; k++) m[8*(5*k) +: 8] = 8'd1;
    return m;
  endfunction

  function automatic logic [127:0] ramp();
    logic [127:0] m;
    for (int k = 0; k < 16; k++) m[8*k +: 8] = 8'(k + 1);
    return m;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({in_ready, out_valid, start, err, out_last, out_data} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b val=%b start=%b err=%b last=%b data=%h, required all 0",
               in_ready, out_valid, start, err, out_last, out_data);
    end
    total++;
    if (a_flat !== '0 || b_flat !== '0) begin
      bad++;
      $display("FAIL reset_flat: a=%h b=%h, required 0", a_flat, b_flat);
    end
    rst = 1'b0;
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_identity();
    run_job(identity(), ramp(), 1'b0, 3, -1, 0, -1);
  endtask

  task automatic test_input_gaps();
    run_job(rand128(), rand128(), 1'b1, 3, -1, 0, -1);
  endtask

  task automatic test_backpressure();
    run_job(identity(), ramp(), 1'b0, 1, 3, 5, -1);
  endtask

  task automatic test_done_filter();
    run_job(rand128(), rand128(), 1'b0, 10, -1, 0, 10);
  endtask

  task automatic test_reset_mid_send();
    logic [127:0] s;
    job_in(rand128(), rand128(), 1'b0, -1, s);
    job_mult(2, s);
    recv(7, -1, 0);
    rst = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_send: out_valid=%b err=%b in_ready=%b, required 0 0 0",
               out_valid, err, in_ready);
    end
    rst = 1'b0;
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_midreset: in_ready=%b, required 1", in_ready);
    end
    exp_q.delete();
    run_job(rand128(), rand128(), 1'b0, 4, -1, 0, -1);
  endtask

  task automatic test_done_vs_timeout();
    sel = 1'b1;
    repeat (2) tick();
    run_job(rand128(), rand128(), 1'b0, 8, -1, 0, -1);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL done_beats_timeout: err=%b, required 0", err);
    end
  endtask

  task automatic test_timeout();
    logic [127:0] a = rand128();
    logic [127:0] b = rand128();
    int           cyc = 0;
    stream_in(a, b, 1'b0, -1);
    total++;
    if (start !== 1'b1) begin
      bad++;
      $display("FAIL timeout_start: start=%b, required 1", start);
    end
    while (err !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    total++;
    if (cyc != 9) begin
      bad++;
      $display("FAIL timeout_latency: err after %0d edges from start, required 9", cyc);
    end
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || a_flat !== a || b_flat !== b) begin
      bad++;
      $display("FAIL timeout_return_load: in_ready=%b out_valid=%b a=%h b=%h, required 1 0 %h %h",
               in_ready, out_valid, a_flat, b_flat, a, b);
    end
    run_job(rand128(), rand128(), 1'b0, 2, -1, 0, -1);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: err=%b, required 1", err);
    end
  endtask

  initial begin
    rst       = 1'b1;
    sel       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    done      = 1'b0;
    s_flat    = '0;
    @(negedge clk);
    test_reset();
    test_identity();
    test_input_gaps();
    test_backpressure();
    test_done_filter();
    test_reset_mid_send();
    test_done_vs_timeout();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
